quantize_multiplier_gen: RTL and testbench

QUANTIZE_MULTIPLIER_GEN -- requirements
Module: quantize_multiplier_gen

---
 rtl/npu_quant_pkg.sv | 19 +
 rtl/serial_div_restoring.sv | 85 ++++++++
 rtl/quantize_multiplier_gen.sv | 206 ++++++++++++++++++++
 tb/tb_quantize_multiplier_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_quant_pkg.sv
// rtl/npu_quant_pkg.sv - shared constants and FSM state type for the quantize multiplier generator
package npu_quant_pkg;

    localparam int DIV_ITERS = 35;
    localparam int LATENCY   = 38;
    localparam int SHIFT_MAX = 30;
    localparam int SHIFT_MIN = -31;

    localparam logic [31:0] Q31_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        NORM,
        OUT
    } state_t;

endpackage

// File: rtl/serial_div_restoring.sv
// rtl/serial_div_restoring.sv - serial restoring divider, one quotient bit per clock
module serial_div_restoring
    import npu_quant_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [57:0] dividend,
    input  logic [23:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [34:0] quotient,
    output logic        rem_nz
);

    // The quotient is known to fit in 35 bits, so the top 23 dividend bits
    // are already below the divisor and seed the partial remainder directly.
    // The low 35 dividend bits shift out of sh_q while quotient bits shift in.
    logic [23:0] rem_q, rem_d;
    logic [34:0] sh_q, sh_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [23:0] cur_rem;
    logic [34:0] cur_sh;
    logic [24:0] trial;
    logic [23:0] diff;
    logic        ge;

    // One restoring step per cycle; start performs the first step immediately
    always_comb begin
        cur_rem = start ? {1'b0, dividend[57:35]} : rem_q;
        cur_sh  = start ? dividend[34:0] : sh_q;
        trial   = {cur_rem, cur_sh[34]};
        ge      = (trial >= {1'b0, divisor});
        diff    = trial[23:0] - divisor;

        rem_d  = rem_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start) begin
            rem_d  = ge ? diff : trial[23:0];
            sh_d   = {cur_sh[33:0], ge};
            cnt_d  = 6'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = ge ? diff : trial[23:0];
            sh_d  = {cur_sh[33:0], ge};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_ITERS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Control flops reset; remainder and shift register are pure datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 6'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        sh_q  <= sh_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = sh_q;
    assign rem_nz   = |rem_q;

endmodule

// File: rtl/quantize_multiplier_gen.sv
// rtl/quantize_multiplier_gen.sv - fp32 scales to Q31 multiplier and shift for the requantizer
module quantize_multiplier_gen
    import npu_quant_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_scale,
    input  logic [31:0] w_scale,
    input  logic [31:0] out_scale,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quantized_multiplier,
    output logic [31:0] shift,
    output logic        err
);

    state_t      state_q, state_d;
    logic [23:0] ma_q, ma_d, mb_q, mb_d, mc_q, mc_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d, ec_q, ec_d;
    logic        sign_q, sign_d;
    logic        sat_q, sat_d;
    logic        zero_q, zero_d;
    logic [47:0] p_q, p_d;
    logic        div_start_q, div_start_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] qm_q, qm_d;
    logic [31:0] shift_q, shift_d;
    logic        err_q, err_d;

    logic        div_busy, div_done, div_rem_nz;
    logic [34:0] div_quo;

    logic [5:0]         lead;
    logic [31:0]        mag_t, mag_r, mag_n;
    logic               guard, lower, above_half, tie, round_up, carry;
    logic [11:0]        shift_n;
    logic signed [31:0] shift_ext;
    logic [31:0]        res_qm, res_shift;
    logic               res_err;

    serial_div_restoring u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_q),
        .dividend ({p_q, 10'd0}),
        .divisor  (mc_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .rem_nz   (div_rem_nz)
    );

    // Normalize: Q has its leading one at bit 32..34; keep 31 bits and round half away
    always_comb begin
        lead  = 6'd32;
        mag_t = {1'b0, div_quo[32:2]};
        guard = div_quo[1];
        lower = div_quo[0];
        if (div_quo[34]) begin
            lead  = 6'd34;
            mag_t = {1'b0, div_quo[34:4]};
            guard = div_quo[3];
            lower = |div_quo[2:0];
        end else if (div_quo[33]) begin
            lead  = 6'd33;
            mag_t = {1'b0, div_quo[33:3]};
            guard = div_quo[2];
            lower = |div_quo[1:0];
        end
        // An exact tie rounds away from zero, anything above half rounds up
        above_half = lower | div_rem_nz;
        tie        = guard & ~above_half;
        round_up   = tie | (guard & above_half);
        mag_r      = mag_t + {31'd0, round_up};
        carry      = mag_r[31];
        mag_n      = carry ? 32'h4000_0000 : mag_r;
        shift_n    = {4'd0, ea_q} + {4'd0, eb_q} - {4'd0, ec_q}
                   + {6'd0, lead} + {11'd0, carry} - 12'd159;
        shift_ext  = {{20{shift_n[11]}}, shift_n};
    end

    // Final result selection: special inputs first, then shift-range clamps
    always_comb begin
        res_qm    = sign_q ? (32'd0 - mag_n) : mag_n;
        res_shift = 32'(shift_ext);
        res_err   = 1'b0;
        if (sat_q) begin
            res_qm    = Q31_MAX;
            res_shift = 32'(SHIFT_MAX);
            res_err   = 1'b1;
        end else if (zero_q || (shift_ext < SHIFT_MIN)) begin
            res_qm    = 32'd0;
            res_shift = 32'd0;
        end else if (shift_ext > SHIFT_MAX) begin
            res_qm    = sign_q ? (32'd0 - Q31_MAX) : Q31_MAX;
            res_shift = 32'(SHIFT_MAX);
            res_err   = 1'b1;
        end
    end

    // Sequencer: unpack, multiply, divide, normalize, hold result until taken
    always_comb begin
        state_d     = state_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        mc_d        = mc_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        ec_d        = ec_q;
        sign_d      = sign_q;
        sat_d       = sat_q;
        zero_d      = zero_q;
        p_d         = p_q;
        div_start_d = 1'b0;
        out_valid_d = out_valid_q;
        qm_d        = qm_q;
        shift_d     = shift_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Hidden bit is always set so the divider sees a normal
                    // divisor even when the flags override the result.
                    ma_d    = {1'b1, in_scale[22:0]};
                    mb_d    = {1'b1, w_scale[22:0]};
                    mc_d    = {1'b1, out_scale[22:0]};
                    ea_d    = in_scale[30:23];
                    eb_d    = w_scale[30:23];
                    ec_d    = out_scale[30:23];
                    sign_d  = in_scale[31] ^ w_scale[31] ^ out_scale[31];
                    sat_d   = (out_scale[30:23] == 8'd0) || (in_scale[30:23] == 8'hFF)
                           || (w_scale[30:23] == 8'hFF) || (out_scale[30:23] == 8'hFF);
                    zero_d  = (in_scale[30:23] == 8'd0) || (w_scale[30:23] == 8'd0);
                    state_d = MUL;
                end
            end
            MUL: begin
                p_d         = {24'd0, ma_q} * {24'd0, mb_q};
                div_start_d = !div_busy;
                state_d     = DIV;
            end
            DIV: begin
                if (div_done) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                qm_d        = res_qm;
                shift_d     = res_shift;
                err_d       = res_err;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            qm_q        <= 32'd0;
            shift_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_start_q <= div_start_d;
            out_valid_q <= out_valid_d;
            qm_q        <= qm_d;
            shift_q     <= shift_d;
            err_q       <= err_d;
        end
    end

    // Unpacked operand and product registers
    always_ff @(posedge clk) begin
        ma_q   <= ma_d;
        mb_q   <= mb_d;
        mc_q   <= mc_d;
        ea_q   <= ea_d;
        eb_q   <= eb_d;
        ec_q   <= ec_d;
        sign_q <= sign_d;
        sat_q  <= sat_d;
        zero_q <= zero_d;
        p_q    <= p_d;
    end

    assign in_ready             = (state_q == IDLE);
    assign out_valid            = out_valid_q;
    assign quantized_multiplier = qm_q;
    assign shift                = shift_q;
    assign err                  = err_q;

endmodule

// File: tb/tb_quantize_multiplier_gen.sv
// tb/tb_quantize_multiplier_gen.sv - self-checking bench for quantize_multiplier_gen
module tb_quantize_multiplier_gen;
    import npu_quant_pkg::*;

    typedef struct {
        logic [31:0] qm;
        logic [31:0] sh;
        logic        err;
    } res_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        res_t        exp_r;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_scale;
    logic [31:0] w_scale;
    logic [31:0] out_scale;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quantized_multiplier;
    logic [31:0] shift;
    logic        err;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    quantize_multiplier_gen dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_scale             (in_scale),
        .w_scale              (w_scale),
        .out_scale            (out_scale),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .quantized_multiplier (quantized_multiplier),
        .shift                (shift),
        .err                  (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    function automatic res_t mk(input logic [31:0] qm, input logic [31:0] sh, input logic e);
        res_t r;
        r.qm = qm;
        r.sh = sh;
        r.err = e;
        return r;
    endfunction

    task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input res_t r);
        vec_t v;
        v.name = n;
        v.a = a;
        v.b = b;
        v.c = c;
        v.exp_r = r;
        tbl.push_back(v);
    endtask

    // Reference: exact integer arithmetic straight from the scale formula
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        res_t r;
        longint unsigned ma, mb, mc, qq, mag, rmd, half;
        int ea, eb, ec, l, sc, sh;
        logic sg;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ec = int'(c[30:23]);
        r = mk(32'd0, 32'd0, 1'b0);
        if (ec == 0 || ea == 255 || eb == 255 || ec == 255)
            return mk(32'h7FFF_FFFF, 32'd30, 1'b1);
        if (ea == 0 || eb == 0)
            return r;
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        mc = {40'd0, 1'b1, c[22:0]};
        qq = ((ma * mb) << 10) / mc;
        l = 0;
        for (int i = 0; i < 64; i++)
            if (qq[i]) l = i;
        sc   = l - 30;
        mag  = qq >> sc;
        rmd  = qq - (mag << sc);
        half = 64'd1 << (sc - 1);
        if (rmd >= half) mag++;
        sh = l + ea + eb - ec - 159;
        if (mag == (64'd1 << 31)) begin
            mag = 64'd1 << 30;
            sh++;
        end
        sg = a[31] ^ b[31] ^ c[31];
        if (sh < -31) begin
            r = mk(32'd0, 32'd0, 1'b0);
        end else if (sh > 30) begin
            r = mk(sg ? 32'h8000_0001 : 32'h7FFF_FFFF, 32'd30, 1'b1);
        end else begin
            r.qm = sg ? (32'd0 - mag[31:0]) : mag[31:0];
            r.sh = 32'(sh);
            r.err = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        e = 8'($urandom_range(100, 154));
        case ($urandom_range(0, 15))
            0: e = 8'd0;
            1: e = 8'd255;
            default: ;
        endcase
        r[30:23] = e;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           output res_t r, output int lat);
        int wait_cnt;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        in_valid  = 1'b1;
        in_scale  = a;
        w_scale   = b;
        out_scale = c;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_scale  = $urandom;
        w_scale   = $urandom;
        out_scale = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r.qm = quantized_multiplier;
        r.sh = shift;
        r.err = err;
    endtask

    task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input res_t exp_r);
        res_t got;
        int   lat;
        run_req(a, b, c, got, lat);
        check({name, " qm"}, got.qm, exp_r.qm);
        check({name, " shift"}, got.sh, exp_r.sh);
        check({name, " err"}, {31'd0, got.err}, {31'd0, exp_r.err});
        check({name, " latency"}, 32'(lat), 32'(LATENCY));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " ready_after"}, {31'd0, in_ready}, 32'd1);
        check({name, " valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        res_t got;
        int   lat;
        int   seen;
        logic [31:0] ra, rb, rc;

        add_vec("unit",      32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'h4000_0000, 32'd1, 1'b0));
        add_vec("third",     32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, mk(32'h5555_5555, 32'hFFFF_FFFF, 1'b0));
        add_vec("neg",       32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'hC000_0000, 32'd1, 1'b0));
        add_vec("tiny",      32'h2B80_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'd0, 32'd0, 1'b0));
        add_vec("huge",      32'h5380_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'h7FFF_FFFF, 32'd30, 1'b1));
        add_vec("outzero",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, mk(32'h7FFF_FFFF, 32'd30, 1'b1));
        add_vec("neghuge",   32'hD380_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'h8000_0001, 32'd30, 1'b1));
        add_vec("inzero",    32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'd0, 32'd0, 1'b0));
        add_vec("winf",      32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000, mk(32'h7FFF_FFFF, 32'd30, 1'b1));
        add_vec("shmin",     32'h2F80_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'h4000_0000, 32'hFFFF_FFE1, 1'b0));
        add_vec("belowmin",  32'h2F00_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'd0, 32'd0, 1'b0));
        add_vec("shmax",     32'h4E00_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'h4000_0000, 32'd30, 1'b0));
        add_vec("abovemax",  32'h4E80_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'h7FFF_FFFF, 32'd30, 1'b1));
        add_vec("three",     32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0000, mk(32'h6000_0000, 32'd2, 1'b0));
        add_vec("roundcarry",32'h3FFF_FFFD, 32'h3FAA_AAAB, 32'h3FAA_AAA9, mk(32'h4000_0000, 32'd2, 1'b0));

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_scale  = 32'd0;
        w_scale   = 32'd0;
        out_scale = 32'd0;
        repeat (3) @(negedge clk);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst qm", quantized_multiplier, 32'd0);
        check("rst shift", shift, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);

        foreach (tbl[i])
            do_req(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp_r);

        // Back-pressure: result held, no new request taken while stalled
        run_req(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, got, lat);
        check("stall first qm", got.qm, 32'h5555_5555);
        check("stall latency", 32'(lat), 32'(LATENCY));
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            in_scale  = 32'h4000_0000;
            w_scale   = 32'h4000_0000;
            out_scale = 32'h3F80_0000;
            @(negedge clk);
            check("stall qm", quantized_multiplier, 32'h5555_5555);
            check("stall shift", shift, 32'hFFFF_FFFF);
            check("stall err", {31'd0, err}, 32'd0);
            check("stall valid", {31'd0, out_valid}, 32'd1);
            check("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall idle in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        do_req("after stall", 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'hC000_0000, 32'd1, 1'b0));

        // Reset in the middle of the divide discards the request
        in_valid  = 1'b1;
        in_scale  = 32'h3F80_0000;
        w_scale   = 32'h3F80_0000;
        out_scale = 32'h3F80_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("div busy in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("midrst no output", 32'(seen), 32'd0);
        do_req("after midrst", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, mk(32'h4000_0000, 32'd1, 1'b0));

        // Randomized operands against the reference model
        for (int n = 0; n < 30; n++) begin
            ra = rand_fp();
            rb = rand_fp();
            rc = rand_fp();
            do_req($sformatf("rand%0d %h %h %h", n, ra, rb, rc), ra, rb, rc, model(ra, rb, rc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
